cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have clock and reset as follows: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_valid  input  1  instruction data valid; completes the fetch.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  latched instruction register, decoded as the shared instruction_t.
REQ-010 branch_taken  input  1  B_TYPE compare result from the ALU; sampled in WRITEBACK.
REQ-011 target_pc  input  32  branch/jump target from the datapath; sampled in WRITEBACK.
REQ-012 dmem_req  output  1  data store request.
REQ-013 dmem_we  output  1  store write enable; equals dmem_req.
REQ-014 dmem_ready  input  1  store accepted.
REQ-015 rf_we  output  1  register-file write strobe.
REQ-016 pc  output  32  current program counter.
REQ-017 retired  output  1  one-cycle pulse per completed instruction.
REQ-018 trap  output  1  sticky fault flag.
REQ-019 state  output  3  encoded FSM state for debug.

Function
REQ-020 FSM states SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5; other codes SHALL go to TRAP.
REQ-021 FETCH SHALL assert imem_req; if imem_valid=1, latch imem_rdata into instr and go to DECODE; otherwise stay with imem_addr held.
REQ-022 DECODE (1 cycle) SHALL go to TRAP if opcode instr[6:0] is not I_TYPE, R_TYPE, S_TYPE, B_TYPE, U_TYPE or J_TYPE; otherwise go to EXECUTE.
REQ-023 EXECUTE (1 cycle) SHALL go to MEM for S_TYPE; otherwise go to WRITEBACK.
REQ-024 MEM SHALL assert dmem_req=dmem_we=1 until the cycle dmem_ready=1, then go to WRITEBACK.
REQ-025 WRITEBACK (1 cycle) SHALL pulse rf_we for I/R/U/J opcodes when rd (instr[11:7]) is not 0; never for S/B.
REQ-026 WRITEBACK next pc SHALL be: target_pc for J_TYPE, or for B_TYPE with branch_taken=1; otherwise pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-027 If the selected target_pc has bits [1:0] not 0, WRITEBACK SHALL go to TRAP, leave pc unchanged, suppress rf_we, and suppress retired.
REQ-028 Otherwise WRITEBACK SHALL pulse retired, update pc, and return to FETCH.
REQ-029 TRAP SHALL hold trap=1 and pc, deassert all requests and strobes, and stay until reset.
REQ-030 Latency with zero-wait memories: 4 cycles per non-store instruction, 5 for S_TYPE; each imem/dmem wait cycle adds 1.
REQ-031 imem_valid outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-032 imem_req, dmem_req and rf_we SHALL be registered-state decodes with no combinational path from any input.

Reset
REQ-033 rst=1 SHALL immediately, without a clock, force state=FETCH, pc=RESET_PC, instr=0, trap=0, and all of imem_req, dmem_req, dmem_we, rf_we, retired to 0.
REQ-034 imem_req SHALL first assert on the first clock edge after rst deasserts.
REQ-035 Reset asserted mid-fetch or mid-store SHALL abandon the transaction with no retired pulse or rf_we.

Verification
REQ-036 ADDI x1 (32'h0050_0093), zero-wait imem -> imem_req cycle 1; rf_we and retired in cycle 4; pc 0 -> 4.
REQ-037 SW (opcode 0100011), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles; no rf_we; retired in cycle 8.
REQ-038 B_TYPE with branch_taken=1, target_pc=32'h40 -> pc=32'h40; rf_we=0; with branch_taken=0 -> pc+4.
REQ-039 Illegal opcode 7'b0000000 -> TRAP after DECODE; trap=1 sticky; no further imem_req until rst.
REQ-040 J_TYPE with target_pc=32'h42 -> TRAP; pc unchanged; no rf_we, no retired. Separately, pc=32'hFFFF_FFFC ADDI -> pc=0.
REQ-041 rst asserted in MEM with dmem_req=1 -> dmem_req drops asynchronously; pc=RESET_PC; state=FETCH.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch and data-store handshake bundle between the sequencer and its memories.
//   imem_req   : fetch request (sequencer -> imem)
//   imem_addr  : fetch address, always the current pc
//   imem_valid : fetch data valid, completes the fetch (imem -> sequencer)
//   imem_rdata : fetched instruction word
//   dmem_req   : store request (sequencer -> dmem)
//   dmem_we    : store write enable, mirrors dmem_req
//   dmem_ready : store accepted (dmem -> sequencer)
interface cpu_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_valid, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_valid, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK.
// Ports:
//   clk, rst      : single clock, asynchronous active-high reset
//   bus           : imem fetch / dmem store handshake (master side)
//   instr         : latched instruction register
//   branch_taken  : B-type compare result, used in WRITEBACK
//   target_pc     : branch/jump target from the datapath, used in WRITEBACK
//   rf_we         : register-file write strobe (registered)
//   pc            : current program counter
//   retired       : one-cycle pulse per completed instruction
//   trap          : sticky fault flag, cleared only by reset
//   state         : encoded FSM state for debug
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus,
    output logic [31:0]     instr,
    input  logic            branch_taken,
    input  logic [31:0]     target_pc,
    output logic            rf_we,
    output logic [31:0]     pc,
    output logic            retired,
    output logic            trap,
    output logic [2:0]      state
);

    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpSType = 7'b0100011;
    localparam logic [6:0] OpBType = 7'b1100011;
    localparam logic [6:0] OpUType = 7'b0110111;
    localparam logic [6:0] OpJType = 7'b1101111;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        rf_we_q, rf_we_d;

    logic [6:0]  opcode;
    logic        is_i, is_r, is_s, is_b, is_u, is_j;
    logic        legal_op;
    logic        writes_rd;
    logic        take_target;
    logic        target_misaligned;
    logic        retire_now;

    assign opcode            = instr_q[6:0];
    assign is_i              = (opcode == OpIType);
    assign is_r              = (opcode == OpRType);
    assign is_s              = (opcode == OpSType);
    assign is_b              = (opcode == OpBType);
    assign is_u              = (opcode == OpUType);
    assign is_j              = (opcode == OpJType);
    assign legal_op          = is_i | is_r | is_s | is_b | is_u | is_j;
    assign writes_rd         = (is_i | is_r | is_u | is_j) && (instr_q[11:7] != 5'd0);
    assign take_target       = is_j | (is_b & branch_taken);
    assign target_misaligned = (target_pc[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retire_now = 1'b0;

        case (state_q)
            StFetch: begin
                // The first FETCH cycle after reset has imem_req low; no fetch is open yet.
                if (imem_req_q && bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = legal_op ? StExecute : StTrap;
            end
            StExecute: begin
                state_d = is_s ? StMem : StWriteback;
            end
            StMem: begin
                if (bus.dmem_ready) begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                if (take_target && target_misaligned) begin
                    state_d = StTrap;
                end else begin
                    pc_d       = take_target ? target_pc : pc_q + 32'd4;
                    retire_now = 1'b1;
                    state_d    = StFetch;
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase

        // Strobes are flops loaded from the next state so they carry no path from inputs.
        imem_req_d = (state_d == StFetch);
        dmem_req_d = (state_d == StMem);
        // A jump's target is formed from registered pc/imm and is stable from EXECUTE on,
        // so its alignment is checked one cycle early to keep rf_we a pure flop output.
        rf_we_d    = (state_d == StWriteback) && writes_rd && !(is_j && target_misaligned);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            rf_we_q    <= rf_we_d;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_req_q;
    assign instr         = instr_q;
    assign rf_we         = rf_we_q;
    assign pc            = pc_q;
    assign retired       = retire_now;
    assign trap          = (state_q == StTrap);
    assign state         = state_q;

endmodule
